// File: rtl/fm_cmn_pkg.sv
// Shared definitions for the common block-RAM FIFO blocks: FSM encoding and the
// level/length width rule.
package fm_cmn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } st_e;

    // FIFO level and burst length carry one extra bit so a completely full FIFO is representable
    function automatic int unsigned lvl_w(input int unsigned range);
        return range + 1;
    endfunction

endpackage

// File: rtl/fm_cmn_burst_timeout.sv
// Idle timeout counter for the burst reader; expires on the P_TIMEOUT-th enabled cycle
// after a clear. Only instantiated when FM_CMN_BURST_RD_TIMEOUT_EN is defined.
module fm_cmn_burst_timeout #(
    parameter int unsigned P_TIMEOUT = 64,
    parameter int unsigned P_TO_W    = 8
) (
    input  logic clk_core,
    input  logic rst_x,
    input  logic i_clr,
    input  logic i_cnt_en,
    output logic o_expire
);

    localparam logic [P_TO_W-1:0] LV_LAST = P_TO_W'(P_TIMEOUT - 1);

    logic [P_TO_W-1:0] r_cnt;

    // Saturates at LV_LAST so a held enable never wraps back to zero
    always_ff @(posedge clk_core) begin
        if (rst_x || i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en && (r_cnt != LV_LAST)) begin
            r_cnt <= r_cnt + P_TO_W'(1);
        end
    end

    assign o_expire = i_cnt_en & (r_cnt == LV_LAST);

endmodule

// File: rtl/fm_cmn_bfifo_burst_rd.sv
// Downstream burst reader for the common block-RAM FIFO: requests a write burst once enough
// words are queued and pops exactly the granted count. FM_CMN_BURST_RD_TIMEOUT_EN adds a
// partial flush after an idle timeout.
module fm_cmn_bfifo_burst_rd
    import fm_cmn_pkg::*;
#(
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned P_RANGE   = 8,
    parameter int unsigned P_BURST   = 16,
    parameter int unsigned P_TIMEOUT = 64,
    parameter int unsigned P_TO_W    = 8
) (
    input  logic                        clk_core,
    input  logic                        rst_x,
    input  logic                        i_empty,
    input  logic [lvl_w(P_RANGE)-1:0]   i_dnum,
    input  logic [P_WIDTH-1:0]          i_dt,
    output logic                        o_renable,
    output logic                        o_req,
    output logic [lvl_w(P_RANGE)-1:0]   o_len,
    input  logic                        i_ack,
    output logic                        o_wstrobe,
    output logic [P_WIDTH-1:0]          o_wdt,
    input  logic                        i_wbusy,
    output logic                        o_busy
);

    localparam int unsigned   LW       = lvl_w(P_RANGE);
    localparam logic [LW-1:0] LV_BURST = LW'(P_BURST);

    st_e                r_state;
    logic               r_req;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_rem;
    logic               r_wstrobe;
    logic [P_WIDTH-1:0] r_wdt;

    logic w_full;
    logic w_pop;
    logic w_flush;

    assign w_full = (i_dnum >= LV_BURST);
    assign w_pop  = (r_state == ST_DATA) & ~i_wbusy & ~i_empty & (r_rem != '0);

`ifdef FM_CMN_BURST_RD_TIMEOUT_EN
    logic w_to_en;
    logic w_to_clr;

    assign w_to_en  = (r_state == ST_IDLE) & ~i_empty & ~w_full;
    assign w_to_clr = i_empty | (r_state != ST_IDLE);

    fm_cmn_burst_timeout #(
        .P_TIMEOUT (P_TIMEOUT),
        .P_TO_W    (P_TO_W)
    ) u_timeout (
        .clk_core (clk_core),
        .rst_x    (rst_x),
        .i_clr    (w_to_clr),
        .i_cnt_en (w_to_en),
        .o_expire (w_flush)
    );
`else
    logic w_unused_to;

    assign w_unused_to = ^{P_TIMEOUT[0], P_TO_W[0]};
    assign w_flush     = 1'b0;
`endif

    always_ff @(posedge clk_core) begin
        if (rst_x) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_len     <= '0;
            r_rem     <= '0;
            r_wstrobe <= 1'b0;
            r_wdt     <= '0;
        end else begin
            r_wstrobe <= w_pop;
            if (w_pop) begin
                r_wdt <= i_dt;
            end
            case (r_state)
                ST_IDLE: begin
                    // A full burst outranks a timeout expiring in the same cycle
                    if (w_full) begin
                        r_len   <= LV_BURST;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end else if (w_flush) begin
                        r_len   <= i_dnum;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_ack) begin
                        r_rem   <= r_len;
                        r_req   <= 1'b0;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_pop) begin
                        r_rem <= r_rem - LW'(1);
                        if (r_rem == LW'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_renable = w_pop;
    assign o_req     = r_req;
    assign o_len     = r_len;
    assign o_wstrobe = r_wstrobe;
    assign o_wdt     = r_wdt;
    assign o_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fm_cmn_bfifo_burst_rd.sv
// Directed bench for fm_cmn_bfifo_burst_rd: two instances (P_BURST=16 and P_BURST=256) fed
// by simple FIFO models whose data word equals its write index.
module tb_fm_cmn_bfifo_burst_rd;

    localparam int unsigned W  = 32;
    localparam int unsigned R  = 8;
    localparam int unsigned LW = R + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sel;
    logic ack;
    logic wbusy;
    int   push_a;
    int   push_b;
    logic flush_a;

    int a_wr, a_rd, b_wr, b_rd;

    logic          a_empty, b_empty;
    logic [LW-1:0] a_dnum, b_dnum;
    logic [W-1:0]  a_dt, b_dt;
    logic          a_ren, a_req, a_strobe, a_busy;
    logic          b_ren, b_req, b_strobe, b_busy;
    logic [LW-1:0] a_len, b_len;
    logic [W-1:0]  a_wdt, b_wdt;

    logic          m_ren, m_req, m_strobe, m_busy;
    logic [LW-1:0] m_len;
    logic [W-1:0]  m_wdt;

    int checks = 0;
    int errors = 0;

    assign a_empty = (a_wr == a_rd);
    assign b_empty = (b_wr == b_rd);
    assign a_dnum  = LW'(a_wr - a_rd);
    assign b_dnum  = LW'(b_wr - b_rd);
    assign a_dt    = W'(a_rd);
    assign b_dt    = W'(b_rd);

    always_ff @(posedge clk) begin
        a_wr <= a_wr + push_a;
        b_wr <= b_wr + push_b;
        a_rd <= flush_a ? a_wr : a_rd + int'(a_ren);
        b_rd <= b_rd + int'(b_ren);
    end

    always_comb begin
        m_ren    = sel ? b_ren    : a_ren;
        m_req    = sel ? b_req    : a_req;
        m_strobe = sel ? b_strobe : a_strobe;
        m_busy   = sel ? b_busy   : a_busy;
        m_len    = sel ? b_len    : a_len;
        m_wdt    = sel ? b_wdt    : a_wdt;
    end

    fm_cmn_bfifo_burst_rd #(
        .P_WIDTH (W),
        .P_RANGE (R),
        .P_BURST (16)
    ) u_dut_a (
        .clk_core  (clk),
        .rst_x     (rst),
        .i_empty   (a_empty),
        .i_dnum    (a_dnum),
        .i_dt      (a_dt),
        .o_renable (a_ren),
        .o_req     (a_req),
        .o_len     (a_len),
        .i_ack     (ack & ~sel),
        .o_wstrobe (a_strobe),
        .o_wdt     (a_wdt),
        .i_wbusy   (wbusy & ~sel),
        .o_busy    (a_busy)
    );

    fm_cmn_bfifo_burst_rd #(
        .P_WIDTH (W),
        .P_RANGE (R),
        .P_BURST (256)
    ) u_dut_b (
        .clk_core  (clk),
        .rst_x     (rst),
        .i_empty   (b_empty),
        .i_dnum    (b_dnum),
        .i_dt      (b_dt),
        .o_renable (b_ren),
        .o_req     (b_req),
        .o_len     (b_len),
        .i_ack     (ack & sel),
        .o_wstrobe (b_strobe),
        .o_wdt     (b_wdt),
        .i_wbusy   (wbusy & sel),
        .o_busy    (b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n);
        if (sel) push_b = n;
        else     push_a = n;
        tick();
        push_a = 0;
        push_b = 0;
    endtask

    // Wait for a request, grant it after dly cycles, then collect len words starting at first
    task automatic burst(input int len, input int first, input bit alt, input int dly);
        int n;
        int got;
        int want_d;
        n = 0;
        while (!m_req && n < 40) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(m_req), 1);
        chk("req_len", 32'(m_len), len);
        repeat (dly) begin
            tick();
            chk("req_hold", 32'({m_req, m_len}), 32'({1'b1, LW'(len)}));
        end
        ack   = 1'b1;
        wbusy = alt;
        tick();
        ack = 1'b0;
        chk("req_drop", 32'(m_req), 0);
        chk("busy_data", 32'(m_busy), 1);
        got    = 0;
        want_d = first;
        n      = 0;
        while (got < len && n < len * 3 + 20) begin
            if (alt) wbusy = (n % 2 == 0);
            #1;
            if (alt) chk("ren_while_busy", 32'(m_ren & wbusy), 0);
            tick();
            n++;
            if (m_strobe) begin
                chk("wdt", m_wdt, want_d);
                want_d++;
                got++;
            end
        end
        chk("strobe_count", got, len);
        chk("idle_at_last", 32'(m_busy), 0);
        wbusy = 1'b0;
        tick();
        chk("no_extra_strobe", 32'(m_strobe), 0);
    endtask

    initial begin
        int n;
        sel     = 1'b0;
        ack     = 1'b0;
        wbusy   = 1'b0;
        push_a  = 0;
        push_b  = 0;
        flush_a = 1'b0;
        rst     = 1'b1;
        repeat (2) tick();
        chk("rst_ren", 32'(m_ren), 0);
        chk("rst_req", 32'(m_req), 0);
        chk("rst_len", 32'(m_len), 0);
        chk("rst_strobe", 32'(m_strobe), 0);
        chk("rst_wdt", m_wdt, 0);
        chk("rst_busy", 32'(m_busy), 0);
        rst = 1'b0;
        tick();

        // Full bursts: plain, then with alternating sink stall
        push(16);
        burst(16, 0, 1'b0, 3);
        push(16);
        burst(16, 16, 1'b1, 3);

        // Reset mid-burst after 7 pops
        push(16);
        n = 0;
        while (!m_req && n < 40) begin
            tick();
            n++;
        end
        chk("t5_req", 32'(m_req), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n = 0;
        repeat (7) begin
            tick();
            if (m_strobe) n++;
        end
        chk("t5_pre_strobes", n, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ren", 32'(m_ren), 0);
        chk("t5_req", 32'(m_req), 0);
        chk("t5_len", 32'(m_len), 0);
        chk("t5_strobe", 32'(m_strobe), 0);
        chk("t5_wdt", m_wdt, 0);
        chk("t5_busy", 32'(m_busy), 0);
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        n = 0;
        repeat (20) begin
            tick();
            if (m_strobe || m_busy) n++;
        end
        chk("t5_quiet", n, 0);

        // Stray grant in IDLE is ignored
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t6_req", 32'(m_req), 0);
        chk("t6_busy", 32'(m_busy), 0);
        tick();
        chk("t6_busy2", 32'(m_busy), 0);
        push(16);
        burst(16, 48, 1'b0, 1);

        // Residue below P_BURST
        push(5);
`ifdef FM_CMN_BURST_RD_TIMEOUT_EN
        n = 0;
        while (!m_req && n < 200) begin
            tick();
            n++;
        end
        chk("t3_timeout_cycles", n, 64);
        burst(5, 64, 1'b0, 1);
`else
        n = 0;
        repeat (1000) begin
            tick();
            if (m_req) n++;
        end
        chk("t3_no_req", n, 0);
`endif

        // Full-depth burst on the P_BURST=256 instance
        sel = 1'b1;
        push(256);
        burst(256, 0, 1'b0, 1);
        chk("t4_len", 32'(m_len), 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
